// File: rtl/dds_param_pkg.sv
// Shared constants for the keypad-to-DDS parameter stage: key codes, limits, reset values.
// Optional FM deviation control is built when DDS_FD_CTRL_EN is defined.
`timescale 1ns/1ps
package dds_param_pkg;

   typedef enum logic [1:0] {
      MODE_SIN = 2'd0,
      MODE_AM  = 2'd1,
      MODE_FM  = 2'd2
   } mode_t;

   typedef enum logic [1:0] {
      RPT_IDLE  = 2'd0,
      RPT_FIRST = 2'd1,
      RPT_WAIT  = 2'd2,
      RPT_RPT   = 2'd3
   } rpt_state_t;

   // Keypad codes are one-hot row nibble / one-hot column nibble.
   localparam logic [15:0] KEY_NONE      = 16'h0000;
   localparam logic [15:0] KEY_MODE_SIN  = 16'h0011;
   localparam logic [15:0] KEY_MODE_AM   = 16'h0012;
   localparam logic [15:0] KEY_MODE_FM   = 16'h0014;
   localparam logic [15:0] KEY_FS_UP10   = 16'h0021;
   localparam logic [15:0] KEY_FS_DN10   = 16'h0041;
   localparam logic [15:0] KEY_FS_UP1K   = 16'h0022;
   localparam logic [15:0] KEY_FS_DN1K   = 16'h0042;
   localparam logic [15:0] KEY_FS_UP100K = 16'h0024;
   localparam logic [15:0] KEY_FS_DN100K = 16'h0044;
   localparam logic [15:0] KEY_FC_UP     = 16'h0018;
   localparam logic [15:0] KEY_FC_DN     = 16'h0028;
   localparam logic [15:0] KEY_MA_UP     = 16'h0048;
   localparam logic [15:0] KEY_MA_DN     = 16'h0088;
   localparam logic [15:0] KEY_FD_UP     = 16'h0081;
   localparam logic [15:0] KEY_FD_DN     = 16'h0082;

   localparam logic [23:0] FC_MIN     = 24'd500_000;
   localparam logic [23:0] FC_MAX     = 24'd10_000_000;
   localparam logic [23:0] FC_RST     = 24'd10_000_000;
   localparam logic [23:0] FS_MIN     = 24'd1_000;
   localparam logic [23:0] FS_MAX_SIN = 24'd10_000_000;
   localparam logic [23:0] FS_MAX_MOD = 24'd50_000;
   localparam logic [23:0] FS_RST     = 24'd1_000;
   localparam logic [3:0]  MA_MIN     = 4'd1;
   localparam logic [3:0]  MA_MAX     = 4'd10;
   localparam logic [3:0]  MA_RST     = 4'd10;
   localparam logic [14:0] FD_MIN     = 15'd5_000;
   localparam logic [14:0] FD_MAX     = 15'd20_000;
   localparam logic [14:0] FD_RST     = 15'd5_000;

   // The 25-bit signed sum cannot wrap for any value/step pair used here.
   function automatic logic [23:0] sat_add(
      input logic        [23:0] v,
      input logic signed [24:0] step,
      input logic        [23:0] lo,
      input logic        [23:0] hi
   );
      logic signed [24:0] sum;
      sum = $signed({1'b0, v}) + step;
      if (sum < $signed({1'b0, lo})) begin
         sat_add = lo;
      end else if (sum > $signed({1'b0, hi})) begin
         sat_add = hi;
      end else begin
         sat_add = sum[23:0];
      end
   endfunction

   function automatic logic [23:0] fs_max(input mode_t m);
      fs_max = (m == MODE_SIN) ? FS_MAX_SIN : FS_MAX_MOD;
   endfunction

endpackage

// File: rtl/dds_key_repeat.sv
// Key capture register and press/auto-repeat FSM; emits one act pulse per press
// and timed repeats while the same code is held.
`timescale 1ns/1ps
module dds_key_repeat
   import dds_param_pkg::*;
#(
   parameter int REPEAT_DLY = 5,
   parameter int REPEAT_PER = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [15:0] i_key_code,
   output logic        o_act,
   output logic [15:0] o_code,
   output rpt_state_t  o_state
);

   localparam logic [7:0] DLY_LAST = 8'(REPEAT_DLY - 1);
   localparam logic [7:0] PER_LAST = 8'(REPEAT_PER - 1);

   rpt_state_t  r_state;
   rpt_state_t  w_state_nx;
   logic [15:0] r_key_q;
   logic [15:0] r_key_prev;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_nx;
   logic        w_zero;
   logic        w_same;

   assign w_zero = (r_key_q == KEY_NONE);
   assign w_same = (r_key_q == r_key_prev);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= RPT_IDLE;
         r_key_q    <= KEY_NONE;
         r_key_prev <= KEY_NONE;
         r_cnt      <= 8'd0;
      end else begin
         r_state    <= w_state_nx;
         r_key_q    <= i_key_code;
         r_key_prev <= r_key_q;
         r_cnt      <= w_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      if (w_zero) begin
         w_state_nx = RPT_IDLE;
         w_cnt_nx   = 8'd0;
      end else if (!w_same) begin
         w_state_nx = RPT_FIRST;
         w_cnt_nx   = 8'd0;
      end else begin
         case (r_state)
            RPT_IDLE: begin
               w_state_nx = RPT_FIRST;
               w_cnt_nx   = 8'd0;
            end
            RPT_FIRST: begin
               w_state_nx = RPT_WAIT;
               w_cnt_nx   = 8'd1;
            end
            RPT_WAIT: begin
               if (r_cnt == DLY_LAST) begin
                  w_state_nx = RPT_RPT;
                  w_cnt_nx   = 8'd0;
               end else begin
                  w_cnt_nx = r_cnt + 8'd1;
               end
            end
            RPT_RPT: begin
               if (r_cnt == PER_LAST) begin
                  w_cnt_nx = 8'd0;
               end else begin
                  w_cnt_nx = r_cnt + 8'd1;
               end
            end
            default: begin
               w_state_nx = RPT_IDLE;
               w_cnt_nx   = 8'd0;
            end
         endcase
      end
   end

   // o_act qualifies o_code for exactly one cycle; there is no back-pressure.
   always_comb begin
      o_act = 1'b0;
      if (!w_zero) begin
         if (!w_same) begin
            o_act = 1'b1;
         end else begin
            case (r_state)
               RPT_IDLE: o_act = 1'b1;
               RPT_WAIT: o_act = (r_cnt == DLY_LAST);
               RPT_RPT:  o_act = (r_cnt == PER_LAST);
               default:  o_act = 1'b0;
            endcase
         end
      end
   end

   assign o_code  = r_key_q;
   assign o_state = r_state;

endmodule

// File: rtl/dds_param_ctrl.sv
// Keypad-driven parameter registers (mode, fc, fs, ma, fd) for the DDS/AM path.
// Define DDS_FD_CTRL_EN to enable FM mode selection and fd stepping.
`timescale 1ns/1ps
module dds_param_ctrl
   import dds_param_pkg::*;
#(
   parameter int REPEAT_DLY = 5,
   parameter int REPEAT_PER = 1
) (
   input  logic        clk_5Hz,
   input  logic        rst_n,
   input  logic [15:0] key_code,
   output logic [1:0]  mode,
   output logic [23:0] fc,
   output logic [23:0] fs,
   output logic [3:0]  ma,
   output logic [14:0] fd,
   output logic        param_upd,
   output logic        key_err,
   output logic [1:0]  dbg_rpt_state
);

   logic        w_act;
   logic [15:0] w_code;
   rpt_state_t  w_rpt_state;

   mode_t       r_mode;
   mode_t       w_mode_nx;
   logic [23:0] r_fc;
   logic [23:0] w_fc_nx;
   logic [23:0] r_fs;
   logic [23:0] w_fs_nx;
   logic [3:0]  r_ma;
   logic [3:0]  w_ma_nx;
   logic        r_upd;
   logic        r_err;
   logic        w_err_nx;
   logic        w_changed;
`ifdef DDS_FD_CTRL_EN
   logic [14:0] r_fd;
   logic [14:0] w_fd_nx;
`endif

   dds_key_repeat #(
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
   ) u_key_repeat (
      .i_clk      (clk_5Hz),
      .i_rst_n    (rst_n),
      .i_key_code (key_code),
      .o_act      (w_act),
      .o_code     (w_code),
      .o_state    (w_rpt_state)
   );

   always_comb begin
      w_mode_nx = r_mode;
      w_fc_nx   = r_fc;
      w_fs_nx   = r_fs;
      w_ma_nx   = r_ma;
      w_err_nx  = 1'b0;
`ifdef DDS_FD_CTRL_EN
      w_fd_nx   = r_fd;
`endif
      if (w_act) begin
         case (w_code)
            // A mode switch re-clamps fs into the new mode's range in the same edge.
            KEY_MODE_SIN: begin
               w_mode_nx = MODE_SIN;
               w_fs_nx   = sat_add(r_fs, 25'sd0, FS_MIN, fs_max(MODE_SIN));
            end
            KEY_MODE_AM: begin
               w_mode_nx = MODE_AM;
               w_fs_nx   = sat_add(r_fs, 25'sd0, FS_MIN, fs_max(MODE_AM));
            end
            KEY_FS_UP10: begin
               if (r_mode == MODE_SIN || r_mode == MODE_AM)
                  w_fs_nx = sat_add(r_fs, 25'sd10, FS_MIN, fs_max(r_mode));
            end
            KEY_FS_DN10: begin
               if (r_mode == MODE_SIN || r_mode == MODE_AM)
                  w_fs_nx = sat_add(r_fs, -25'sd10, FS_MIN, fs_max(r_mode));
            end
            KEY_FS_UP1K: begin
               if (r_mode == MODE_SIN)
                  w_fs_nx = sat_add(r_fs, 25'sd1_000, FS_MIN, FS_MAX_SIN);
            end
            KEY_FS_DN1K: begin
               if (r_mode == MODE_SIN)
                  w_fs_nx = sat_add(r_fs, -25'sd1_000, FS_MIN, FS_MAX_SIN);
            end
            KEY_FS_UP100K: begin
               if (r_mode == MODE_SIN)
                  w_fs_nx = sat_add(r_fs, 25'sd100_000, FS_MIN, FS_MAX_SIN);
            end
            KEY_FS_DN100K: begin
               if (r_mode == MODE_SIN)
                  w_fs_nx = sat_add(r_fs, -25'sd100_000, FS_MIN, FS_MAX_SIN);
            end
            KEY_FC_UP: w_fc_nx = sat_add(r_fc, 25'sd10, FC_MIN, FC_MAX);
            KEY_FC_DN: w_fc_nx = sat_add(r_fc, -25'sd10, FC_MIN, FC_MAX);
            KEY_MA_UP: w_ma_nx = 4'(sat_add({20'd0, r_ma}, 25'sd1,
                                            {20'd0, MA_MIN}, {20'd0, MA_MAX}));
            KEY_MA_DN: w_ma_nx = 4'(sat_add({20'd0, r_ma}, -25'sd1,
                                            {20'd0, MA_MIN}, {20'd0, MA_MAX}));
`ifdef DDS_FD_CTRL_EN
            KEY_MODE_FM: begin
               w_mode_nx = MODE_FM;
               w_fs_nx   = sat_add(r_fs, 25'sd0, FS_MIN, fs_max(MODE_FM));
            end
            KEY_FD_UP: w_fd_nx = 15'(sat_add({9'd0, r_fd}, 25'sd1_000,
                                            {9'd0, FD_MIN}, {9'd0, FD_MAX}));
            KEY_FD_DN: w_fd_nx = 15'(sat_add({9'd0, r_fd}, -25'sd1_000,
                                            {9'd0, FD_MIN}, {9'd0, FD_MAX}));
`endif
            default: w_err_nx = 1'b1;
         endcase
      end
   end

   // param_upd reflects a real value change, so saturated no-ops stay silent.
   always_comb begin
      w_changed = (w_mode_nx != r_mode) || (w_fc_nx != r_fc) ||
                  (w_fs_nx != r_fs) || (w_ma_nx != r_ma);
`ifdef DDS_FD_CTRL_EN
      w_changed = w_changed || (w_fd_nx != r_fd);
`endif
   end

   always_ff @(posedge clk_5Hz or negedge rst_n) begin
      if (!rst_n) begin
         r_mode <= MODE_SIN;
         r_fc   <= FC_RST;
         r_fs   <= FS_RST;
         r_ma   <= MA_RST;
         r_upd  <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_mode <= w_mode_nx;
         r_fc   <= w_fc_nx;
         r_fs   <= w_fs_nx;
         r_ma   <= w_ma_nx;
         r_upd  <= w_changed;
         r_err  <= w_err_nx;
      end
   end

`ifdef DDS_FD_CTRL_EN
   always_ff @(posedge clk_5Hz or negedge rst_n) begin
      if (!rst_n) begin
         r_fd <= FD_RST;
      end else begin
         r_fd <= w_fd_nx;
      end
   end

   assign fd = r_fd;
`else
   assign fd = FD_RST;
`endif

   assign mode          = r_mode;
   assign fc            = r_fc;
   assign fs            = r_fs;
   assign ma            = r_ma;
   assign param_upd     = r_upd;
   assign key_err       = r_err;
   assign dbg_rpt_state = w_rpt_state;

endmodule
